// File: rtl/serial_pkg.sv
// Shared definitions for the serial byte transmit/receive pair: state encodings,
// line levels and data width.
package serial_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam logic TX_IDLE_LEVEL = 1'b1;
    localparam logic START_LEVEL   = 1'b0;
    localparam logic STOP_LEVEL    = 1'b1;

    function automatic logic even_parity(input logic [DATA_W-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/tx_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and ticks on the
// terminal count; also reports whether the following cycle will be terminal.
module tx_baud_counter #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_tick,
    output logic o_last_next
);

    localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

    logic [7:0] r_count;
    logic [7:0] w_count_next;

    assign o_tick = i_en && (r_count == LAST);

    always_comb begin
        w_count_next = r_count;
        if (i_clear || o_tick) begin
            w_count_next = 8'd0;
        end else if (i_en) begin
            w_count_next = r_count + 8'd1;
        end
    end

    // Lets the parent register a pulse that lines up with the final cycle of a bit.
    assign o_last_next = (w_count_next == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= 8'd0;
        end else begin
            r_count <= w_count_next;
        end
    end

endmodule

// File: rtl/serial_byte_tx.sv
// Framed LSB-first byte transmitter: start, 8 data bits, optional even parity
// (enabled by defining SERIAL_TX_PARITY_EN), stop. All outputs are registered.
module serial_byte_tx
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] d,
    input  logic              en,
    output logic              ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    tx_state_t         r_state;
    tx_state_t         w_state_next;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_next;
    logic [2:0]        r_idx;
    logic [2:0]        w_idx_next;
    logic              r_tx;
    logic              r_ready;
    logic              r_busy;
    logic              r_done;
    logic              w_tx_next;
    logic              w_tick;
    logic              w_last_next;
`ifdef SERIAL_TX_PARITY_EN
    logic              r_parity;
    logic              w_parity_next;
`endif

    tx_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (r_state == ST_IDLE),
        .i_en       (r_state != ST_IDLE),
        .o_tick     (w_tick),
        .o_last_next(w_last_next)
    );

    always_comb begin
        w_state_next  = r_state;
        w_shift_next  = r_shift;
        w_idx_next    = r_idx;
`ifdef SERIAL_TX_PARITY_EN
        w_parity_next = r_parity;
`endif
        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_state_next  = ST_START;
                    w_shift_next  = d;
`ifdef SERIAL_TX_PARITY_EN
                    w_parity_next = even_parity(d);
`endif
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_next = ST_DATA;
                    w_idx_next   = 3'd0;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_shift_next = r_shift >> 1;
                    if (r_idx == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
                        w_state_next = ST_PARITY;
`else
                        w_state_next = ST_STOP;
`endif
                    end else begin
                        w_idx_next = r_idx + 3'd1;
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: begin
                if (w_tick) begin
                    w_state_next = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_tick) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase

        // Line level is decided from the upcoming state so tx is a plain flop.
        w_tx_next = TX_IDLE_LEVEL;
        case (w_state_next)
            ST_START:  w_tx_next = START_LEVEL;
            ST_DATA:   w_tx_next = w_shift_next[0];
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: w_tx_next = w_parity_next;
`endif
            ST_STOP:   w_tx_next = STOP_LEVEL;
            default:   w_tx_next = TX_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_shift  <= '0;
            r_idx    <= 3'd0;
            r_tx     <= TX_IDLE_LEVEL;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_next;
            r_shift  <= w_shift_next;
            r_idx    <= w_idx_next;
            r_tx     <= w_tx_next;
            r_ready  <= (w_state_next == ST_IDLE);
            r_busy   <= (w_state_next != ST_IDLE);
            r_done   <= (w_state_next == ST_STOP) && w_last_next;
`ifdef SERIAL_TX_PARITY_EN
            r_parity <= w_parity_next;
`endif
        end
    end

    assign tx    = r_tx;
    assign ready = r_ready;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_serial_byte_tx.sv
// Bench for serial_byte_tx: drivers push expected bytes, a line monitor decodes
// frames from tx and compares them against the queue.
module tb_serial_byte_tx;

`ifdef SERIAL_TX_PARITY_EN
    localparam int CLKS  = 1;
    localparam int NBITS = 11;
`else
    localparam int CLKS  = 4;
    localparam int NBITS = 10;
`endif
    localparam int FR = NBITS * CLKS;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] d   = 8'h00;
    logic       en  = 1'b0;
    logic       ready, tx, busy, done;

    logic [7:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int sent   = 0;
    int seen   = 0;

    serial_byte_tx #(.CLKS_PER_BIT(CLKS)) dut (
        .clk  (clk),
        .rst  (rst),
        .d    (d),
        .en   (en),
        .ready(ready),
        .tx   (tx),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // One bit period on the line; entered on the negedge of its first cycle.
    task automatic read_bit(input logic lvl, input bit is_stop, input string name, output bit ab);
        ab = 1'b0;
        for (int c = 0; c < CLKS; c++) begin
            if (c > 0) @(negedge clk);
            if (!rst) begin
                ab = 1'b1;
                return;
            end
            chk(name, tx, lvl);
            chk("frame_busy", busy, 1);
            chk("frame_ready", ready, 0);
            chk("frame_done", done, (is_stop && c == CLKS - 1));
        end
    endtask

    initial begin : monitor
        logic [7:0] eb;
        bit ab;
        forever begin
            @(negedge clk);
            if (rst && tx) begin
                chk("idle_done", done, 0);
                chk("idle_busy", busy, 0);
                chk("idle_ready", ready, 1);
            end else if (rst && !tx) begin
                eb = 8'h00;
                if (exp_q.size() == 0) chk("unexpected_frame", 1, 0);
                else eb = exp_q[0];
                read_bit(1'b0, 1'b0, "start_bit", ab);
                for (int i = 0; i < 8; i++) begin
                    if (!ab) begin
                        @(negedge clk);
                        read_bit(eb[i], 1'b0, "data_bit", ab);
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                if (!ab) begin
                    @(negedge clk);
                    read_bit(^eb, 1'b0, "parity_bit", ab);
                end
`endif
                if (!ab) begin
                    @(negedge clk);
                    read_bit(1'b1, 1'b1, "stop_bit", ab);
                end
                if (!ab) begin
                    @(negedge clk);
                    if (rst) begin
                        chk("post_frame_ready", ready, 1);
                        chk("post_frame_tx", tx, 1);
                        chk("post_frame_busy", busy, 0);
                    end
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    seen++;
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        wait_ready();
        d = b;
        en = 1'b1;
        exp_q.push_back(b);
        sent++;
        @(negedge clk);
        en = 1'b0;
        chk("accept_latency_tx", tx, 0);
        chk("accept_busy", busy, 1);
        chk("accept_ready", ready, 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin : stimulus
        int r;
        // Reset held, then idle.
        repeat (3) begin
            @(negedge clk);
            chk("reset_tx", tx, 1);
            chk("reset_ready", ready, 1);
            chk("reset_busy", busy, 0);
            chk("reset_done", done, 0);
        end
        rst = 1'b1;
        repeat (20) @(negedge clk);

        send_byte(8'hA5);

        // Back-to-back with en held: exactly one idle cycle between frames.
        @(negedge clk);
        wait_ready();
        d = 8'h00;
        en = 1'b1;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        sent += 2;
        @(negedge clk);
        d = 8'hFF;
        wait_ready();
        chk("b2b_gap_tx", tx, 1);
        @(negedge clk);
        en = 1'b0;
        chk("b2b_second_start_tx", tx, 0);
        chk("b2b_second_busy", busy, 1);

        // Inputs churn while busy; frame must still carry 3C and no extra frame appears.
        send_byte(8'h3C);
        for (int i = 0; i < FR - 5; i++) begin
            d = i[7:0];
            en = i[0];
            @(negedge clk);
        end
        en = 1'b0;
        @(negedge clk);
        wait_ready();
        repeat (2 * FR) @(negedge clk);
        chk("no_extra_frames", seen, sent);

        // Reset mid-frame.
        send_byte(8'h81);
        r = (FR - 2 < 17) ? FR - 2 : 17;
        repeat (r - 1) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midreset_tx", tx, 1);
        chk("midreset_ready", ready, 1);
        chk("midreset_busy", busy, 0);
        chk("midreset_done", done, 0);
        void'(exp_q.pop_back());
        sent--;
        repeat (2) begin
            @(negedge clk);
            chk("midreset_hold_done", done, 0);
        end
        rst = 1'b1;
        send_byte(8'h81);

`ifdef SERIAL_TX_PARITY_EN
        send_byte(8'h07);
        send_byte(8'h03);
`endif

        // Random bytes with random idle gaps.
        for (int k = 0; k < 12; k++) begin
            send_byte(8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        @(negedge clk);
        wait_ready();
        repeat (4) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        chk("frames_seen", seen, sent);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
